// File: rtl/fifo_read_streamer.sv
// Pops words from a FIFO with one-cycle registered read data and presents them as a
// valid/ready stream, with optional fixed-length packet framing and a beat counter.
module fifo_read_streamer #(
  parameter int DW      = 8,
  parameter int PKT_LEN = 0,
  parameter int CW      = 16
) (
  input  logic          rclk,
  input  logic          rrst,
  input  logic          fifo_rempty,
  input  logic [DW-1:0] fifo_rdata,
  output logic          fifo_ren,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  input  logic          flush,
  output logic [CW-1:0] word_count
);

  logic [1:0]    occ_reg, occ_next;
  logic [1:0]    head_reg, head_next;
  logic [1:0]    tail_reg, tail_next;
  logic          inflight_reg;
  logic [DW-1:0] buf_reg [3];
  logic [CW-1:0] word_count_reg;
  logic [2:0]    fill;
  logic          capture;
  logic          deq;

  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Words already buffered plus the one in flight must fit in the three slots.
  assign fill      = {1'b0, occ_reg} + {2'b00, inflight_reg};
  assign fifo_ren  = !rrst && !flush && !fifo_rempty && (fill < 3'd3);
  assign capture   = inflight_reg && !flush;
  assign out_valid = (occ_reg != 2'd0);
  assign deq       = out_valid && out_ready;
  assign word_count = word_count_reg;

  always_comb begin
    out_data = buf_reg[0];
    case (head_reg)
      2'd1:    out_data = buf_reg[1];
      2'd2:    out_data = buf_reg[2];
      default: ;
    endcase
  end

  always_comb begin
    occ_next  = occ_reg;
    head_next = head_reg;
    tail_next = tail_reg;
    if (deq)
      head_next = next_ptr(head_reg);
    if (capture)
      tail_next = next_ptr(tail_reg);
    case ({capture, deq})
      2'b10:   occ_next = occ_reg + 2'd1;
      2'b01:   occ_next = occ_reg - 2'd1;
      default: ;
    endcase
    if (flush) begin
      occ_next  = 2'd0;
      head_next = 2'd0;
      tail_next = 2'd0;
    end
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      occ_reg        <= 2'd0;
      head_reg       <= 2'd0;
      tail_reg       <= 2'd0;
      inflight_reg   <= 1'b0;
      word_count_reg <= '0;
      for (int i = 0; i < 3; i++)
        buf_reg[i] <= '0;
    end else begin
      occ_reg      <= occ_next;
      head_reg     <= head_next;
      tail_reg     <= tail_next;
      inflight_reg <= fifo_ren;
      // A beat handshaken in a flush cycle was seen by the consumer, so it still counts.
      if (deq)
        word_count_reg <= word_count_reg + 1'b1;
      for (int i = 0; i < 3; i++)
        if (capture && (tail_reg == 2'(i)))
          buf_reg[i] <= fifo_rdata;
    end
  end

  generate
    if (PKT_LEN > 0) begin : g_frame
      localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
      localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_LEN - 1);
      logic [BW-1:0] beat_reg, beat_next;

      always_comb begin
        beat_next = beat_reg;
        if (deq)
          beat_next = (beat_reg == LAST_BEAT) ? '0 : beat_reg + 1'b1;
        if (flush)
          beat_next = '0;
      end

      always_ff @(posedge rclk) begin
        if (rrst)
          beat_reg <= '0;
        else
          beat_reg <= beat_next;
      end

      assign out_last = out_valid && (beat_reg == LAST_BEAT);
    end else begin : g_noframe
      assign out_last = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_read_streamer.sv
// Directed bench: three streamer instances (no framing, PKT_LEN=1, PKT_LEN=4) share one
// behavioural FIFO and stimulus; delivered beats are collected and compared to hand tables.
module tb_fifo_read_streamer;

  logic       clk = 1'b0;
  logic       rrst;
  logic       flush;
  logic       out_ready;
  logic       fifo_rempty = 1'b1;
  logic [7:0] fifo_rdata = 8'h00;

  logic        fifo_ren, ren0, ren1;
  logic [7:0]  out_data, d0, d1;
  logic        out_valid, v0, v1;
  logic        out_last, l0, l1;
  logic [15:0] word_count, wc0, wc1;

  typedef struct {
    logic [7:0] data;
    logic       l0;
    logic       l1;
    logic       l4;
    int         cyc;
  } beat_t;

  logic [7:0] q[$];
  beat_t      rx_q[$];
  logic [7:0] exp_mem [1000];
  int  n_vec = 0;
  int  n_bad = 0;
  int  cyc = 0;
  int  pops = 0;
  int  ren_viol = 0;
  int  diverge = 0;
  int  pops_base;
  bit  bubble_en = 1'b0;

  always #5 clk = ~clk;

  fifo_read_streamer #(.DW(8), .PKT_LEN(4), .CW(16)) dut (
    .rclk(clk), .rrst(rrst), .fifo_rempty(fifo_rempty), .fifo_rdata(fifo_rdata),
    .fifo_ren(fifo_ren), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .flush(flush), .word_count(word_count));

  fifo_read_streamer #(.DW(8), .PKT_LEN(0), .CW(16)) dut0 (
    .rclk(clk), .rrst(rrst), .fifo_rempty(fifo_rempty), .fifo_rdata(fifo_rdata),
    .fifo_ren(ren0), .out_data(d0), .out_valid(v0), .out_ready(out_ready),
    .out_last(l0), .flush(flush), .word_count(wc0));

  fifo_read_streamer #(.DW(8), .PKT_LEN(1), .CW(16)) dut1 (
    .rclk(clk), .rrst(rrst), .fifo_rempty(fifo_rempty), .fifo_rdata(fifo_rdata),
    .fifo_ren(ren1), .out_data(d1), .out_valid(v1), .out_ready(out_ready),
    .out_last(l1), .flush(flush), .word_count(wc1));

  // Behavioural FIFO: registered empty flag, read data valid the cycle after a pop.
  always @(posedge clk) begin
    logic stall;
    if (fifo_ren && q.size() > 0)
      fifo_rdata <= q.pop_front();
    stall = bubble_en && ($urandom_range(0, 2) == 0);
    fifo_rempty <= (q.size() == 0) || stall;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_ren)
      pops <= pops + 1;
    if (!rrst && fifo_ren && fifo_rempty)
      ren_viol <= ren_viol + 1;
    if (!rrst && out_valid && out_ready)
      rx_q.push_back('{out_data, l0, l1, out_last, cyc});
  end

  // The unframed and PKT_LEN=1 instances must track the main one except for out_last.
  always @(negedge clk) begin
    if (ren0 != fifo_ren || ren1 != fifo_ren || v0 != out_valid || v1 != out_valid ||
        d0 != out_data || d1 != out_data || wc0 != word_count || wc1 != word_count ||
        l0 != 1'b0 || l1 != out_valid)
      diverge <= diverge + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_rx(input int n, input int budget);
    int k = 0;
    while (rx_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("rx_count", rx_q.size(), n);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rrst = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rrst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    for (int i = 1; i <= 16; i++) q.push_back(8'(i));

    // Reset held for two edges with data waiting in the FIFO.
    repeat (2) begin
      @(negedge clk);
      chk("rst_ren", fifo_ren, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_last", out_last, 0);
      chk("rst_wc", word_count, 0);
      chk("rst_data", out_data, 0);
    end
    rrst = 1'b0;
    out_ready = 1'b1;
    rx_q.delete();
    #1 chk("first_ren", fifo_ren, 1);
    @(negedge clk);
    chk("lat_t1_valid", out_valid, 0);
    @(negedge clk);
    chk("lat_t2_valid", out_valid, 1);
    chk("lat_t2_data", out_data, 8'h01);

    // Streaming 16 words at full rate, PKT_LEN=4 framing on 4,8,12,16.
    wait_rx(16, 200);
    for (int i = 0; i < 16 && i < rx_q.size(); i++)
      chk($sformatf("stream_beat%0d", i),
          {rx_q[i].l0, rx_q[i].l1, rx_q[i].l4, rx_q[i].data},
          {1'b0, 1'b1, (i % 4 == 3), 8'(i + 1)});
    if (rx_q.size() >= 16)
      chk("stream_span", rx_q[15].cyc - rx_q[0].cyc, 15);
    repeat (3) @(negedge clk);
    chk("stream_wc", word_count, 16);
    chk("stream_ren_idle", fifo_ren, 0);
    chk("stream_valid_idle", out_valid, 0);

    // Backpressure from the start: exactly three pops, head held.
    out_ready = 1'b0;
    do_reset();
    for (int i = 1; i <= 16; i++) q.push_back(8'(i));
    @(negedge clk);
    rrst = 1'b0;
    rx_q.delete();
    pops_base = pops;
    repeat (10) @(negedge clk);
    chk("bp_pops", pops - pops_base, 3);
    chk("bp_ren", fifo_ren, 0);
    chk("bp_valid", out_valid, 1);
    chk("bp_data", out_data, 8'h01);
    chk("bp_wc", word_count, 0);
    out_ready = 1'b1;
    wait_rx(16, 200);
    for (int i = 0; i < 16 && i < rx_q.size(); i++)
      chk($sformatf("bp_beat%0d", i), rx_q[i].data, 8'(i + 1));
    repeat (3) @(negedge clk);

    // Flush with two words buffered and the third in flight.
    out_ready = 1'b0;
    rx_q.delete();
    pops_base = pops;
    for (int i = 1; i <= 8; i++) q.push_back(8'(i));
    for (int k = 0; k < 20 && !((pops - pops_base) == 3 && !fifo_ren); k++)
      @(negedge clk);
    chk("fl_reach", pops - pops_base, 3);
    chk("fl_pre_valid", out_valid, 1);
    chk("fl_pre_data", out_data, 8'h01);
    flush = 1'b1;
    #1 chk("fl_ren_gated", fifo_ren, 0);
    @(negedge clk);
    flush = 1'b0;
    chk("fl_valid", out_valid, 0);
    chk("fl_wc", word_count, 16);
    out_ready = 1'b1;
    wait_rx(5, 50);
    for (int i = 0; i < 5 && i < rx_q.size(); i++)
      chk($sformatf("fl_beat%0d", i),
          {rx_q[i].l1, rx_q[i].l4, rx_q[i].data}, {1'b1, (i == 3), 8'(i + 4)});
    repeat (3) @(negedge clk);
    chk("fl_wc_after", word_count, 21);

    // Random empty bubbles and random backpressure over 1000 words.
    do_reset();
    bubble_en = 1'b1;
    rrst = 1'b0;
    rx_q.delete();
    for (int i = 0; i < 1000; i++) begin
      exp_mem[i] = 8'((i * 37 + 11) & 8'hFF);
      q.push_back(exp_mem[i]);
    end
    for (int k = 0; k < 20000 && rx_q.size() < 1000; k++) begin
      @(negedge clk);
      out_ready = 1'($urandom_range(0, 1));
    end
    chk("bub_count", rx_q.size(), 1000);
    for (int i = 0; i < 1000 && i < rx_q.size(); i++)
      chk($sformatf("bub_word%0d", i), rx_q[i].data, exp_mem[i]);
    out_ready = 1'b0;
    bubble_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("bub_wc", word_count, 1000);
    chk("ren_while_empty", ren_viol, 0);
    chk("inst_agree", diverge, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
